// File: rtl/serial_audio_pkg.sv
// Shared definitions for the serial audio encoder/decoder pair:
// the framing state encoding and the normalised LR channel values.
package serial_audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sa_state_t;

  // Normalised LR clock level (after polarity correction)
  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

endpackage

// File: rtl/serial_audio_word_register.sv
// One-entry valid/ready holding register for decoded words.
// A completed word arriving while the previous one is still unaccepted
// is dropped and flagged on is_overrun; the held word is left untouched.
module serial_audio_word_register #(
  parameter int data_width = 32
) (
  input  logic                  sclk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_left,
  input  logic                  o_ready,
  output logic                  o_valid,
  output logic [data_width-1:0] o_data,
  output logic                  o_is_left,
  output logic                  is_overrun
);

  logic load;

  // Slot is free when empty or being drained this cycle
  assign load = !o_valid || o_ready;

  // Hold, replace or drop the incoming word; track overrun
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_is_left  <= 1'b0;
      is_overrun <= 1'b0;
    end else if (in_valid) begin
      if (load) begin
        o_valid    <= 1'b1;
        o_data     <= in_data;
        o_is_left  <= in_left;
        is_overrun <= 1'b0;
      end else begin
        is_overrun <= 1'b1;
      end
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_audio_decoder.sv
// Serial audio receiver: deserialises an I2S or left-justified stream
// (MSB first, data_width bits per slot) into per-channel words.
// Optional build macro:
//   SERIAL_AUDIO_DECODER_DROP_SHORT_EN - discard short frames silently
//   instead of emitting them MSB-aligned with zero-filled LSBs.
module serial_audio_decoder
  import serial_audio_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  sclk,
  input  logic                  reset,
  input  logic                  is_i2s,
  input  logic                  lrclk_polarity,
  input  logic                  ilrclk,
  input  logic                  isdat,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_is_left,
  output logic [data_width-1:0] o_data,
  output logic                  is_overrun
);

  localparam int CW = $clog2(data_width + 1);

  logic                  lr_n, lr_d, lr_eff, lr_q, lr_edge;
  sa_state_t             state;
  logic [CW-1:0]         count;
  logic [data_width-1:0] shreg;
  logic                  frame_left;
  logic                  done_vld;
  logic [data_width-1:0] done_word;
  logic                  done_left;
  logic [data_width-1:0] full_word;

  assign lr_n      = ilrclk ^ lrclk_polarity;
  // I2S puts the MSB one cycle after the LR edge; delaying LR aligns both formats
  assign lr_eff    = is_i2s ? lr_d : lr_n;
  assign lr_edge   = lr_eff != lr_q;
  assign full_word = {shreg[data_width-2:0], isdat};

`ifndef SERIAL_AUDIO_DECODER_DROP_SHORT_EN
  logic [data_width-1:0] short_word;
  // Partial word left-aligned so the received bits keep their MSB weight
  assign short_word = shreg << (CW'(data_width) - count);
`endif

  // LR history; reset to right so the line must move to left to start a frame
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      lr_d <= LR_RIGHT;
      lr_q <= LR_RIGHT;
    end else begin
      lr_d <= lr_n;
      lr_q <= lr_eff;
    end
  end

  // Framing FSM: capture on LR edge, shift data_width bits, then wait
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      shreg      <= '0;
      frame_left <= 1'b0;
      done_vld   <= 1'b0;
      done_word  <= '0;
      done_left  <= 1'b0;
    end else begin
      done_vld <= 1'b0;
      if (lr_edge) begin
`ifndef SERIAL_AUDIO_DECODER_DROP_SHORT_EN
        if (state == ST_SHIFT) begin
          done_vld  <= 1'b1;
          done_word <= short_word;
          done_left <= frame_left;
        end
`endif
        shreg      <= {{(data_width-1){1'b0}}, isdat};
        count      <= CW'(1);
        frame_left <= (lr_eff == LR_LEFT);
        state      <= ST_SHIFT;
      end else begin
        case (state)
          ST_SHIFT: begin
            shreg <= full_word;
            count <= count + CW'(1);
            if (count == CW'(data_width - 1)) begin
              state     <= ST_DONE;
              done_vld  <= 1'b1;
              done_word <= full_word;
              done_left <= frame_left;
            end
          end
          ST_IDLE, ST_DONE: state <= state;
          default:          state <= ST_IDLE;
        endcase
      end
    end
  end

  serial_audio_word_register #(
    .data_width(data_width)
  ) u_word_reg (
    .sclk      (sclk),
    .reset     (reset),
    .in_valid  (done_vld),
    .in_data   (done_word),
    .in_left   (done_left),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_is_left (o_is_left),
    .is_overrun(is_overrun)
  );

endmodule

// File: tb/tb_serial_audio_decoder.sv
// Bench for serial_audio_decoder: builds line streams from slot lists,
// derives expected words/timing from slot arithmetic, and checks every cycle.
module tb_serial_audio_decoder;

  localparam int W = 16;

  logic         sclk = 1'b0;
  logic         reset = 1'b1;
  logic         is_i2s = 1'b0;
  logic         lrclk_polarity = 1'b0;
  logic         ilrclk = 1'b1;
  logic         isdat = 1'b0;
  logic         o_ready = 1'b0;
  logic         o_valid, o_is_left, is_overrun;
  logic [W-1:0] o_data;

  always #5 sclk = ~sclk;

  serial_audio_decoder #(.data_width(W)) dut (
    .sclk          (sclk),
    .reset         (reset),
    .is_i2s        (is_i2s),
    .lrclk_polarity(lrclk_polarity),
    .ilrclk        (ilrclk),
    .isdat         (isdat),
    .o_valid       (o_valid),
    .o_ready       (o_ready),
    .o_is_left     (o_is_left),
    .o_data        (o_data),
    .is_overrun    (is_overrun)
  );

  typedef struct {
    bit           left;
    int           len;
    logic [W-1:0] word;
    bit           sup;   // slot interrupted by reset: never yields a word
  } slot_t;

  typedef struct {
    int           t;
    bit           vld;
    logic [W-1:0] data;
    bit           left;
    bit           ovr;
  } pin_t;

  slot_t        slots[$];
  pin_t         pins[$];
  bit           lr_a[$], dat_a[$], rdy_a[$], rst_a[$], cv[$], cl[$];
  logic [W-1:0] cw[$];

  bit           m_vld, m_left, m_ovr;
  logic [W-1:0] m_data;
  int           n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  function automatic void add_slot(input bit left, input int len, input logic [W-1:0] word, input bit sup = 1'b0);
    slot_t s;
    s.left = left; s.len = len; s.word = word; s.sup = sup;
    slots.push_back(s);
  endfunction

  function automatic void add_pin(input int t, input bit vld, input logic [W-1:0] data, input bit left, input bit ovr);
    pin_t p;
    p.t = t; p.vld = vld; p.data = data; p.left = left; p.ovr = ovr;
    pins.push_back(p);
  endfunction

  // rdy_mode: 0 always ready, 1 random ready, 2 stalled until cycle 52
  task automatic run(input bit i2s, input bit pol, input int rdy_mode, input int rst_at, input int rst_len);
    int           starts[$];
    int           n, c;
    bit           last_lr, ok, rdy;
    logic [W-1:0] w;
    lr_a.delete(); dat_a.delete(); rdy_a.delete(); rst_a.delete();
    cv.delete(); cw.delete(); cl.delete();
    for (int i = 0; i < 3; i++) begin
      lr_a.push_back(1'b1); dat_a.push_back(1'($urandom));
    end
    last_lr = 1'b1;
    foreach (slots[k]) begin
      starts.push_back(lr_a.size());
      last_lr = slots[k].left ? 1'b0 : 1'b1;
      for (int i = 0; i < slots[k].len; i++) begin
        lr_a.push_back(last_lr);
        dat_a.push_back(i < W ? slots[k].word[W-1-i] : 1'($urandom));
      end
    end
    for (int i = 0; i < 20; i++) begin
      lr_a.push_back(last_lr); dat_a.push_back(1'($urandom));
    end
    n = lr_a.size();
    for (int i = 0; i < n + 2; i++) begin
      cv.push_back(1'b0); cw.push_back('0); cl.push_back(1'b0);
    end
    // Completion cycle = cycle the last used bit is sampled (I2S one later)
    foreach (slots[k]) begin
      if (!slots[k].sup) begin
        ok = 1'b1;
        if (slots[k].len >= W) begin
          c = starts[k] + W - 1;
          w = slots[k].word;
        end else begin
          c = starts[k] + slots[k].len;
          w = (slots[k].word >> (W - slots[k].len)) << (W - slots[k].len);
`ifdef SERIAL_AUDIO_DECODER_DROP_SHORT_EN
          ok = 1'b0;
`endif
        end
        if (i2s) c++;
        if (ok) begin
          cv[c] = 1'b1; cw[c] = w; cl[c] = slots[k].left;
        end
      end
    end
    for (int t = 0; t < n; t++) begin
      rst_a.push_back(t >= rst_at && t < rst_at + rst_len);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = (t >= 52);
      endcase
      rdy_a.push_back(rdy);
    end

    reset = 1'b1; is_i2s = i2s; lrclk_polarity = pol;
    ilrclk = 1'b1 ^ pol; isdat = 1'b0; o_ready = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    chk("reset_valid", -1, o_valid, 0);
    chk("reset_data", -1, o_data, 0);
    chk("reset_left", -1, o_is_left, 0);
    chk("reset_overrun", -1, is_overrun, 0);
    m_vld = 0; m_left = 0; m_ovr = 0; m_data = '0;
    reset = 1'b0;

    for (int t = 0; t < n; t++) begin
      reset   = rst_a[t];
      ilrclk  = lr_a[t] ^ pol;
      isdat   = i2s ? (t > 0 ? dat_a[t-1] : 1'b0) : dat_a[t];
      o_ready = rdy_a[t];
      @(posedge sclk);
      // Model: word completed at cycle t-1 is handed off at edge t
      if (rst_a[t]) begin
        m_vld = 0; m_left = 0; m_ovr = 0; m_data = '0;
      end else if (t > 0 && cv[t-1] && !rst_a[t-1]) begin
        if (!m_vld || rdy_a[t]) begin
          m_vld = 1; m_data = cw[t-1]; m_left = cl[t-1]; m_ovr = 0;
        end else begin
          m_ovr = 1;
        end
      end else if (m_vld && rdy_a[t]) begin
        m_vld = 0;
      end
      #1;
      chk("valid", t, o_valid, m_vld);
      chk("overrun", t, is_overrun, m_ovr);
      if (m_vld) begin
        chk("data", t, o_data, m_data);
        chk("is_left", t, o_is_left, m_left);
      end
      foreach (pins[i]) begin
        if (pins[i].t == t) begin
          chk("pin_valid", t, o_valid, pins[i].vld);
          chk("pin_data", t, o_data, pins[i].data);
          chk("pin_left", t, o_is_left, pins[i].left);
          chk("pin_overrun", t, is_overrun, pins[i].ovr);
        end
      end
    end
    slots.delete();
    pins.delete();
  endtask

  initial begin
    // Left-justified, polarity 0: LSB at 18 -> visible at 19
    add_slot(1, W, 16'hA5C3); add_slot(0, W, 16'h0F0F); add_slot(1, W, 16'h1357);
    add_pin(19, 1, 16'hA5C3, 1, 0); add_pin(35, 1, 16'h0F0F, 0, 0);
    run(0, 0, 0, -1, 0);

    // I2S, polarity 1: one more cycle of latency
    add_slot(1, W, 16'hA5C3); add_slot(0, W, 16'h0F0F); add_slot(1, W, 16'h8001);
    add_pin(20, 1, 16'hA5C3, 1, 0); add_pin(36, 1, 16'h0F0F, 0, 0);
    run(1, 1, 0, -1, 0);

    // Stalled consumer: first word held, next two dropped
    add_slot(1, W, 16'h1111); add_slot(0, W, 16'h2222); add_slot(1, W, 16'h3333);
    add_slot(0, W, 16'h4444); add_slot(1, W, 16'h5555);
    add_pin(51, 1, 16'h1111, 1, 1); add_pin(52, 0, 16'h1111, 1, 1);
    add_pin(67, 1, 16'h4444, 0, 0);
    run(0, 0, 2, -1, 0);

    // Short frame: 10 ones then LR toggles
    add_slot(1, 10, 16'hFFFF); add_slot(0, W, 16'h5A5A); add_slot(1, W, 16'h1234);
`ifdef SERIAL_AUDIO_DECODER_DROP_SHORT_EN
    add_pin(14, 0, 16'h0000, 0, 0);
`else
    add_pin(14, 1, 16'hFFC0, 1, 0);
`endif
    add_pin(29, 1, 16'h5A5A, 0, 0);
    run(0, 0, 0, -1, 0);

    // Long slots of 20 cycles: trailing bits ignored
    add_slot(1, 20, 16'hCAFE); add_slot(0, 20, 16'hBEEF); add_slot(1, W, 16'h0FF0);
    add_pin(19, 1, 16'hCAFE, 1, 0); add_pin(39, 1, 16'hBEEF, 0, 0);
    run(0, 0, 0, -1, 0);

    // Reset mid-SHIFT of the right slot; released while still right
    add_slot(1, W, 16'hAAAA); add_slot(0, W, 16'h5555, 1); add_slot(1, W, 16'h1234);
    add_slot(0, W, 16'h4321);
    add_pin(19, 1, 16'hAAAA, 1, 0); add_pin(22, 0, 16'h0000, 0, 0);
    add_pin(51, 1, 16'h1234, 1, 0);
    run(0, 0, 0, 22, 2);

    // Random formats, slot lengths, words and consumer back-pressure
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 12; k++) begin
        int len;
        len = ($urandom_range(0, 4) == 0 && k != 11) ? int'($urandom_range(2, W-1))
                                                     : int'($urandom_range(W, W+5));
        add_slot((k % 2) == 0, len, W'($urandom));
      end
      run(1'($urandom), 1'($urandom), 1, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_audio_decoder.md
# serial_audio_decoder

Serial audio receiver: deserialises an I2S or left-justified stream (bit clock, LR clock, serial data) into parallel per-channel words with a valid/ready output. It is the downstream stage of `serial_audio_encoder` and mirrors its format: MSB first, `data_width` bits per slot, LR-clock polarity selectable. It is used for loopback verification and as the capture path for external ADCs.

## Interface
- `data_width`, default 32: bits per channel word. Must be ≥ 2.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `sclk`, input, 1: bit clock, the only clock. All inputs are sampled on `posedge sclk`.
- `is_i2s`, input, 1: 1 selects I2S (MSB one cycle after the LR edge); 0 selects left-justified (MSB on the LR edge cycle). Quasi-static.
- `lrclk_polarity`, input, 1: XORed with `ilrclk`. Normalised 0 = left, 1 = right.
- `ilrclk`, input, 1: LR clock from the line.
- `isdat`, input, 1: serial data from the line.
- `o_valid`, output, 1: word available. Reset 0.
- `o_ready`, input, 1: consumer accepts the word.
- `o_is_left`, output, 1: channel of `o_data`. Reset 0.
- `o_data`, output, `data_width`: received word. Reset 0.
- `is_overrun`, output, 1: a completed word was dropped. Reset 0.

## Operation
- `lr_n = ilrclk ^ lrclk_polarity`.
- Effective LR value:
  - Left-justified: `lr_eff = lr_n`.
  - I2S: `lr_eff` is `lr_n` delayed one register. The I2S path is otherwise identical to left-justified.
- `lr_q` holds the previous `lr_eff`. Reset value 1, which is right, matching the encoder start state. `edge = lr_eff != lr_q`.
- State machine states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - Data bits are ignored.
  - On `edge`: capture `isdat` as MSB, `count = 1`, `frame_left = !lr_eff`, go to SHIFT.
- SHIFT:
  - Each cycle without `edge`: shift in `isdat`, `count++`.
  - When the `data_width`-th bit is captured: the word is complete, go to DONE.
- DONE:
  - Ignore bits; extra slot bits are discarded.
  - On `edge`: start a new frame, exactly as from IDLE.
- `edge` in SHIFT (short frame, `count < data_width`):
  - The partial word is terminated (see Configuration).
  - The same cycle starts the new frame with its MSB.
- Completed word handoff, using `load = !o_valid || o_ready`:
  - If `load`: register the word and channel, assert `o_valid`, clear `is_overrun`.
  - Else: drop the word and set `is_overrun`. `o_data` is unchanged.
- `o_valid && o_ready` with no completion: `o_valid` falls next cycle.
- `o_valid && o_ready` together with a completion: the new word loads and `o_valid` stays 1.
- `count` width is `$clog2(data_width+1)`. It never wraps, because it is frozen in DONE.
- Reset mid-frame: the partial word is discarded, state returns to IDLE, and `o_valid` goes to 0.

## Timing
- Left-justified: the LSB is sampled at edge N, and `o_valid` / `o_data` update after edge N+1.
- I2S adds one `sclk` cycle of latency.
- A continuous stream yields one word per `data_width` cycles. The consumer must accept within that period to avoid overrun.
- A first `edge` only exists after the line toggles away from right. Left therefore always comes first after reset when the encoder starts.

## Configuration
- `SERIAL_AUDIO_DECODER_DROP_SHORT_EN`
  - Defined: short frames are discarded silently. They do not touch `o_valid` or `is_overrun`.
  - Undefined: short frames are emitted MSB-aligned, i.e. the shift register shifted left by `data_width - count` with zeros in the LSBs. They then follow the normal handoff rules.

## Structure
- Package `serial_audio_pkg`:
  - State encoding (IDLE/SHIFT/DONE).
  - Channel constants (`LR_LEFT = 0`, `LR_RIGHT = 1`).
  - Shared with the encoder.
- Sub-module `serial_audio_word_register`:
  - One-entry valid/ready holding register.
  - Generates `is_overrun`.
  - Parameterised by `data_width`.

## Test plan
- Left-justified, `data_width = 16`, polarity 0: drive words L=16'hA5C3, R=16'h0F0F back-to-back → two outputs in order, `o_is_left` 1 then 0, data exact, one cycle of latency after the LSB.
- I2S, `data_width = 32`, polarity 1: loopback through `serial_audio_encoder` with 32'h80000001 / 32'h7FFFFFFE → identical words received, with latency one cycle more than the left-justified case.
- `o_ready = 0` for 3 frames → first word held; second and third dropped; `is_overrun = 1`. Raise `o_ready` → first word consumed, and the next completed word loads and clears `is_overrun`.
- Short frame: LR toggles after 10 of 16 bits carrying 10'b1111111111:
  - Macro undefined → 16'hFFC0 emitted.
  - Macro defined → no output.
  - In both cases the next full frame decodes correctly.
- Long slot: 20 cycles per slot, `data_width = 16` → only the first 16 bits are used; bits 17-20 are ignored.
- Reset asserted mid-SHIFT, then released → `o_valid = 0`, no partial word emitted; bits are ignored until the next LR edge.
